// File: rtl/hash_request_issuer.sv
// Generic single-clock FIFO, first-word-fall-through.
// Latency: a pushed word is visible on pop_dat the cycle after the push.
// Backpressure: a push is dropped when full unless a pop frees a slot on the same edge.
module hri_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_rdy,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop_rdy && !empty;
    assign do_push = push_vld && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// Host-side request issuer for the Process_Engine hash pipeline; pairs in-order results with requests.
// Latency: request to pe_input_valid 1 cycle; engine result to resp_valid 1 cycle.
// Backpressure: req_ready drops when the issue slot is stalled or RESP_DEPTH requests are in flight.
module hash_request_issuer #(
    parameter int KEY_WIDTH     = 32,
    parameter int VAL_WIDTH     = 32,
    parameter int OPCODE_WIDTH  = 4,
    parameter int RESCODE_WIDTH = 5,
    parameter int RESP_DEPTH    = 8,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [OPCODE_WIDTH-1:0]  req_opcode,
    input  logic [KEY_WIDTH-1:0]     req_key,
    input  logic [VAL_WIDTH-1:0]     req_wr_data,
    output logic                     pe_input_valid,
    output logic [OPCODE_WIDTH-1:0]  pe_opcode,
    output logic [KEY_WIDTH-1:0]     pe_key,
    output logic [VAL_WIDTH-1:0]     pe_wr_data,
    input  logic                     pe_stall,
    input  logic                     pe_output_valid,
    input  logic [VAL_WIDTH-1:0]     pe_val_out,
    input  logic [RESCODE_WIDTH-1:0] pe_rescode,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [OPCODE_WIDTH-1:0]  resp_opcode,
    output logic [KEY_WIDTH-1:0]     resp_key,
    output logic [VAL_WIDTH-1:0]     resp_val,
    output logic [RESCODE_WIDTH-1:0] resp_rescode,
    output logic [CNT_WIDTH-1:0]     issued_count,
    output logic [CNT_WIDTH-1:0]     completed_count,
    output logic                     protocol_error
);
    localparam int CW = $clog2(RESP_DEPTH) + 1;
    localparam int IW = CW + 1;
    localparam logic [OPCODE_WIDTH-1:0] OP_NOP = '0;

    typedef struct packed {
        logic [OPCODE_WIDTH-1:0] opcode;
        logic [KEY_WIDTH-1:0]    key;
        logic [VAL_WIDTH-1:0]    wr_data;
    } hdr_t;

    typedef struct packed {
        logic [OPCODE_WIDTH-1:0] opcode;
        logic [KEY_WIDTH-1:0]    key;
    } trk_t;

    typedef struct packed {
        logic [OPCODE_WIDTH-1:0]  opcode;
        logic [KEY_WIDTH-1:0]     key;
        logic [VAL_WIDTH-1:0]     val;
        logic [RESCODE_WIDTH-1:0] rescode;
    } rsp_t;

    logic          iss_vld;
    hdr_t          iss_dat;
    logic          drain;
    logic          accept;
    logic          load;
    logic [IW-1:0] inflight;

    trk_t          trk_push_dat;
    trk_t          trk_pop_dat;
    logic          trk_pop;
    logic          trk_empty;
    logic [CW-1:0] trk_cnt;

    rsp_t          rsp_push_dat;
    rsp_t          rsp_pop_dat;
    logic          rsp_pop;
    logic          rsp_empty;
    logic [CW-1:0] rsp_cnt;

    // Every accepted request holds a response slot until the host pops it,
    // so an unbackpressured engine result always finds room.
    assign inflight  = IW'(iss_vld) + IW'(trk_cnt) + IW'(rsp_cnt);
    assign drain     = iss_vld && !pe_stall;
    assign req_ready = !reset && (!iss_vld || !pe_stall) && (inflight < IW'(RESP_DEPTH));
    assign accept    = req_valid && req_ready;
    assign load      = accept && (req_opcode != OP_NOP);

    always_ff @(posedge clock) begin
        if (reset) begin
            iss_vld <= 1'b0;
            iss_dat <= '0;
        end else if (load) begin
            iss_vld <= 1'b1;
            iss_dat <= {req_opcode, req_key, req_wr_data};
        end else if (drain) begin
            iss_vld <= 1'b0;
        end
    end

    assign pe_input_valid = iss_vld;
    assign pe_opcode      = iss_dat.opcode;
    assign pe_key         = iss_dat.key;
    assign pe_wr_data     = iss_dat.wr_data;

    assign trk_push_dat = {iss_dat.opcode, iss_dat.key};
    assign trk_pop      = pe_output_valid && !trk_empty;

    hri_fifo #(
        .WIDTH ($bits(trk_t)),
        .DEPTH (RESP_DEPTH)
    ) u_trk_fifo (
        .clock    (clock),
        .reset    (reset),
        .push_vld (drain),
        .push_dat (trk_push_dat),
        .pop_rdy  (trk_pop),
        .pop_dat  (trk_pop_dat),
        .empty    (trk_empty),
        .count    (trk_cnt)
    );

    assign rsp_push_dat = {trk_pop_dat.opcode, trk_pop_dat.key, pe_val_out, pe_rescode};
    assign rsp_pop      = !rsp_empty && resp_ready;

    hri_fifo #(
        .WIDTH ($bits(rsp_t)),
        .DEPTH (RESP_DEPTH)
    ) u_rsp_fifo (
        .clock    (clock),
        .reset    (reset),
        .push_vld (trk_pop),
        .push_dat (rsp_push_dat),
        .pop_rdy  (rsp_pop),
        .pop_dat  (rsp_pop_dat),
        .empty    (rsp_empty),
        .count    (rsp_cnt)
    );

    // FIFO storage is not reset, so response data is masked until valid.
    assign resp_valid   = !rsp_empty;
    assign resp_opcode  = resp_valid ? rsp_pop_dat.opcode  : '0;
    assign resp_key     = resp_valid ? rsp_pop_dat.key     : '0;
    assign resp_val     = resp_valid ? rsp_pop_dat.val     : '0;
    assign resp_rescode = resp_valid ? rsp_pop_dat.rescode : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            issued_count    <= '0;
            completed_count <= '0;
            protocol_error  <= 1'b0;
        end else begin
            if (drain) begin
                issued_count <= issued_count + CNT_WIDTH'(1);
            end
            if (trk_pop) begin
                completed_count <= completed_count + CNT_WIDTH'(1);
            end
            if (pe_output_valid && trk_empty) begin
                protocol_error <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hash_request_issuer.sv
// Bench for hash_request_issuer: the engine is a queue-based hash-table model and the
// issuer is predicted from request/tracker/response queues, with directed scenarios plus a random soak.
module tb_hash_request_issuer;
    localparam int DEPTH = 8;
    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_SRCH = 4'b0001;
    localparam logic [3:0] OP_INS = 4'b0010;
    localparam logic [4:0] RC_OK = 5'd1;
    localparam logic [4:0] RC_HIT = 5'd2;
    localparam logic [4:0] RC_MISS = 5'd3;
    localparam logic [4:0] RC_BAD = 5'h1f;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_opcode;
    logic [31:0] req_key;
    logic [31:0] req_wr_data;
    logic        pe_input_valid;
    logic [3:0]  pe_opcode;
    logic [31:0] pe_key;
    logic [31:0] pe_wr_data;
    logic        pe_stall;
    logic        pe_output_valid;
    logic [31:0] pe_val_out;
    logic [4:0]  pe_rescode;
    logic        resp_valid;
    logic        resp_ready;
    logic [3:0]  resp_opcode;
    logic [31:0] resp_key;
    logic [31:0] resp_val;
    logic [4:0]  resp_rescode;
    logic [31:0] issued_count;
    logic [31:0] completed_count;
    logic        protocol_error;

    hash_request_issuer #(
        .KEY_WIDTH(32), .VAL_WIDTH(32), .OPCODE_WIDTH(4),
        .RESCODE_WIDTH(5), .RESP_DEPTH(DEPTH), .CNT_WIDTH(32)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_key(req_key), .req_wr_data(req_wr_data),
        .pe_input_valid(pe_input_valid), .pe_opcode(pe_opcode), .pe_key(pe_key),
        .pe_wr_data(pe_wr_data), .pe_stall(pe_stall),
        .pe_output_valid(pe_output_valid), .pe_val_out(pe_val_out), .pe_rescode(pe_rescode),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_opcode(resp_opcode),
        .resp_key(resp_key), .resp_val(resp_val), .resp_rescode(resp_rescode),
        .issued_count(issued_count), .completed_count(completed_count),
        .protocol_error(protocol_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] key;
        logic [31:0] dat;
    } req_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] key;
        logic [31:0] dat;
        int          ret;
    } eng_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] key;
        logic [31:0] val;
        logic [4:0]  rc;
    } rsp_t;

    req_t dir_q[$];
    req_t iss_q[$];
    req_t trk_q[$];
    eng_t eng_q[$];
    rsp_t rsp_q[$];
    logic [31:0] tbl [logic [31:0]];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int p_req = 0;
    int p_stall = 0;
    int p_rrdy = 100;
    int dmin = 2;
    int dmax = 2;
    int run_len = 0;
    int max_run = 0;
    logic rst_now = 1'b1;
    logic inject_bad = 1'b0;
    logic [31:0] n_issued = 0;
    logic [31:0] n_completed = 0;
    logic perr_m = 1'b0;
    logic [3:0]  last_resp_op = 0;
    logic [31:0] last_resp_val = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [3:0] rand_op();
        int r = $urandom_range(99);
        if (r < 10) return OP_NOP;
        if (r < 55) return OP_SRCH;
        return OP_INS;
    endfunction

    task automatic step();
        req_t r;
        req_t r2;
        eng_t e;
        rsp_t x;
        logic eo;
        logic [31:0] ev;
        logic [4:0] erc;
        logic e_ready;
        logic e_acc;
        logic e_drain;
        logic e_pop;
        @(negedge clock);
        reset = rst_now;
        req_valid = 1'b0;
        req_opcode = '0;
        req_key = '0;
        req_wr_data = '0;
        r = '{op: OP_NOP, key: 0, dat: 0};
        if (!rst_now) begin
            if (dir_q.size() > 0) begin
                r = dir_q[0];
                req_valid = 1'b1;
            end else if ($urandom_range(99) < p_req) begin
                r.op = rand_op();
                r.key = $urandom_range(15);
                r.dat = $urandom;
                req_valid = 1'b1;
            end
            if (req_valid) begin
                req_opcode = r.op;
                req_key = r.key;
                req_wr_data = r.dat;
            end
        end
        pe_stall = ($urandom_range(99) < p_stall);
        resp_ready = ($urandom_range(99) < p_rrdy);
        eo = 1'b0;
        ev = '0;
        erc = '0;
        if (!rst_now && eng_q.size() > 0 && eng_q[0].ret <= cyc) begin
            e = eng_q.pop_front();
            eo = 1'b1;
            if (e.op == OP_INS) begin
                tbl[e.key] = e.dat;
                ev = e.dat;
                erc = RC_OK;
            end else if (tbl.exists(e.key)) begin
                ev = tbl[e.key];
                erc = RC_HIT;
            end else begin
                erc = RC_MISS;
            end
        end else if (!rst_now && inject_bad) begin
            eo = 1'b1;
            ev = $urandom;
            erc = RC_BAD;
            inject_bad = 1'b0;
        end
        pe_output_valid = eo;
        pe_val_out = ev;
        pe_rescode = erc;
        #1;
        e_ready = (iss_q.size() == 0 || !pe_stall) &&
                  (iss_q.size() + trk_q.size() + rsp_q.size() < DEPTH);
        if (!rst_now) begin
            chk("req_ready", req_ready, e_ready);
            chk("pe_input_valid", pe_input_valid, iss_q.size() != 0);
            if (iss_q.size() != 0) begin
                chk("pe_opcode", pe_opcode, iss_q[0].op);
                chk("pe_key", pe_key, iss_q[0].key);
                chk("pe_wr_data", pe_wr_data, iss_q[0].dat);
            end
            chk("resp_valid", resp_valid, rsp_q.size() != 0);
            if (rsp_q.size() != 0) begin
                chk("resp_opcode", resp_opcode, rsp_q[0].op);
                chk("resp_key", resp_key, rsp_q[0].key);
                chk("resp_val", resp_val, rsp_q[0].val);
                chk("resp_rescode", resp_rescode, rsp_q[0].rc);
            end
            chk("issued_count", issued_count, n_issued);
            chk("completed_count", completed_count, n_completed);
            chk("protocol_error", protocol_error, perr_m);
        end
        if (pe_input_valid === 1'b1) run_len++;
        else run_len = 0;
        if (run_len > max_run) max_run = run_len;

        e_acc = req_valid && e_ready && !rst_now;
        e_drain = (iss_q.size() != 0) && !pe_stall;
        e_pop = (rsp_q.size() != 0) && resp_ready;
        if (rst_now) begin
            iss_q.delete();
            trk_q.delete();
            rsp_q.delete();
            n_issued = 0;
            n_completed = 0;
            perr_m = 1'b0;
        end else begin
            if (e_pop) begin
                last_resp_op = resp_opcode;
                last_resp_val = resp_val;
                void'(rsp_q.pop_front());
            end
            if (eo) begin
                if (trk_q.size() > 0) begin
                    r2 = trk_q.pop_front();
                    x = '{op: r2.op, key: r2.key, val: ev, rc: erc};
                    rsp_q.push_back(x);
                    n_completed++;
                end else begin
                    perr_m = 1'b1;
                end
            end
            if (e_drain) begin
                r2 = iss_q.pop_front();
                trk_q.push_back(r2);
                eng_q.push_back('{op: r2.op, key: r2.key, dat: r2.dat,
                                  ret: cyc + int'($urandom_range(dmax, dmin))});
                n_issued++;
            end
            if (e_acc) begin
                if (dir_q.size() > 0) void'(dir_q.pop_front());
                if (r.op != OP_NOP) iss_q.push_back(r);
            end
        end
        cyc++;
    endtask

    task automatic settle();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((dir_q.size() + iss_q.size() + trk_q.size() + rsp_q.size() + eng_q.size()) != 0
               && n < 400) begin
            step();
            n++;
        end
        chk(tag, (dir_q.size() + iss_q.size() + trk_q.size() + rsp_q.size() + eng_q.size()) == 0, 1);
    endtask

    task automatic push_req(input logic [3:0] op, input logic [31:0] key, input logic [31:0] dat);
        dir_q.push_back('{op: op, key: key, dat: dat});
    endtask

    initial begin
        logic [31:0] base;
        reset = 1'b1;
        req_valid = 0; req_opcode = 0; req_key = 0; req_wr_data = 0;
        pe_stall = 0; pe_output_valid = 0; pe_val_out = 0; pe_rescode = 0; resp_ready = 0;

        rst_now = 1'b1;
        repeat (3) step();
        rst_now = 1'b0;
        settle();
        chk("rst_pe_input_valid", pe_input_valid, 0);
        chk("rst_pe_opcode", pe_opcode, 0);
        chk("rst_pe_key", pe_key, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_issued", issued_count, 0);
        chk("rst_completed", completed_count, 0);
        chk("rst_protocol_error", protocol_error, 0);

        // insert then search the same key
        push_req(OP_INS, 10, 100);
        repeat (50) step();
        push_req(OP_SRCH, 10, 0);
        wait_idle("ins_srch_idle");
        settle();
        chk("ins_srch_issued", issued_count, 2);
        chk("ins_srch_completed", completed_count, 2);
        chk("srch_resp_op", last_resp_op, OP_SRCH);
        chk("srch_resp_val", last_resp_val, 100);

        // stall hold with a second request waiting
        base = n_issued;
        push_req(OP_INS, 5, 32'hdead_beef);
        step();
        push_req(OP_SRCH, 6, 0);
        p_stall = 100;
        repeat (5) step();
        settle();
        chk("stall_req_ready", req_ready, 0);
        chk("stall_issued", issued_count, base);
        p_stall = 0;
        wait_idle("stall_idle");
        settle();
        chk("stall_issued_after", issued_count, base + 2);

        // credit limit with host not consuming
        base = n_issued;
        dmin = 3; dmax = 3;
        p_rrdy = 0;
        for (int i = 0; i < 12; i++) push_req(OP_INS, 32'h100 + i, i);
        repeat (30) step();
        settle();
        chk("credit_issued", issued_count, base + 8);
        chk("credit_req_ready", req_ready, 0);
        p_rrdy = 100;
        step();
        p_rrdy = 0;
        repeat (10) step();
        settle();
        chk("credit_one_more", issued_count, base + 9);
        p_rrdy = 100;
        wait_idle("credit_idle");

        // back-to-back searches
        dmin = 1; dmax = 4;
        for (int i = 0; i < 4; i++) push_req(OP_SRCH, 32'h100 + i, 0);
        run_len = 0;
        max_run = 0;
        wait_idle("b2b_idle");
        chk("b2b_run", max_run, 4);

        // result with nothing outstanding
        base = n_completed;
        inject_bad = 1'b1;
        repeat (6) step();
        settle();
        chk("perr_set", protocol_error, 1);
        chk("perr_no_resp", resp_valid, 0);
        chk("perr_completed", completed_count, base);

        // reset with three requests in flight
        dmin = 20; dmax = 20;
        for (int i = 0; i < 3; i++) push_req(OP_SRCH, 32'h200 + i, 0);
        repeat (6) step();
        rst_now = 1'b1;
        step();
        rst_now = 1'b0;
        settle();
        chk("mrst_pe_input_valid", pe_input_valid, 0);
        chk("mrst_pe_key", pe_key, 0);
        chk("mrst_resp_valid", resp_valid, 0);
        chk("mrst_issued", issued_count, 0);
        chk("mrst_completed", completed_count, 0);
        chk("mrst_protocol_error", protocol_error, 0);
        dmin = 1; dmax = 6;
        wait_idle("mrst_idle");
        settle();
        chk("stale_perr", protocol_error, 1);
        chk("stale_completed", completed_count, 0);

        // random soak with bursts of host backpressure
        p_req = 70; p_stall = 30;
        for (int ph = 0; ph < 6; ph++) begin
            p_rrdy = (ph % 2 == 0) ? 60 : 0;
            repeat (400) step();
        end
        p_req = 0; p_stall = 20; p_rrdy = 100;
        wait_idle("soak_idle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
